// File: rtl/cpu_tlb_setassoc_pkg.sv
// Shared types and sizing helpers for the set-associative TLB (cpu_tlb_setassoc).
package cpu_tlb_pkg;

   typedef enum logic {IDLE, FLUSH} tlb_state_t;

   // Vector width for an index into n items; never zero so ports stay legal when n == 1.
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int tag_bits(input int key_w, input int sets);
      return key_w - $clog2(sets);
   endfunction

   // Packed width of one {valid, tag, value} entry.
   function automatic int entry_bits(input int tag_w, input int value_w);
      return 1 + tag_w + value_w;
   endfunction

endpackage

// File: rtl/cpu_tlb_setassoc_if.sv
// Lookup/insert/flush bus between the address-generation stage and the TLB.
interface cpu_tlb_setassoc_if #(
   parameter int KEY_WIDTH   = 16,
   parameter int VALUE_WIDTH = 16
);
   logic [KEY_WIDTH-1:0]   key;
   logic                   lookup;
   logic                   write;
   logic [VALUE_WIDTH-1:0] value;
   logic                   flush;
   logic                   busy;
   logic                   hit;
   logic [VALUE_WIDTH-1:0] out;

   modport master (output key, lookup, write, value, flush, input busy, hit, out);
   modport slave  (input key, lookup, write, value, flush, output busy, hit, out);
endinterface

// File: rtl/cpu_tlb_rr_ptr.sv
// Per-set round-robin victim pointers for cpu_tlb_setassoc.
module cpu_tlb_rr_ptr
   import cpu_tlb_pkg::*;
#(
   parameter int SETS = 2,
   parameter int WAYS = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [idx_bits(SETS)-1:0] set,
   input  logic                      advance,
   input  logic                      clear_set,
   output logic [idx_bits(WAYS)-1:0] victim
);
   localparam int WW = idx_bits(WAYS);

   logic [WW-1:0] ptr [SETS];

   assign victim = ptr[set];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < SETS; s++) ptr[s] <= '0;
      end else if (clear_set) begin
         ptr[set] <= '0;
      end else if (advance) begin
         ptr[set] <= (ptr[set] == WW'(WAYS - 1)) ? '0 : ptr[set] + 1'b1;
      end
   end

endmodule

// File: rtl/cpu_tlb_setassoc.sv
// Set-associative TLB with registered lookup, round-robin replacement and a per-set flush sequencer.
// Optional CPU_TLB_STATS_EN adds saturating hit/miss counters.
module cpu_tlb_setassoc
   import cpu_tlb_pkg::*;
#(
   parameter int SETS        = 2,
   parameter int WAYS        = 2,
   parameter int KEY_WIDTH   = 16,
   parameter int VALUE_WIDTH = 16
) (
   input  logic              clock,
   input  logic              reset,
   cpu_tlb_setassoc_if.slave bus
`ifdef CPU_TLB_STATS_EN
   ,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
`endif
);
   localparam int IW    = idx_bits(SETS);
   localparam int WW    = idx_bits(WAYS);
   localparam int TAG_W = tag_bits(KEY_WIDTH, SETS);

   typedef struct packed {
      logic                   valid;
      logic [TAG_W-1:0]       tag;
      logic [VALUE_WIDTH-1:0] value;
   } entry_t;

   entry_t                 mem [SETS][WAYS];
   tlb_state_t             state_q, state_d;
   logic [IW-1:0]          fcnt_q, fcnt_d;
   logic [IW-1:0]          idx;
   logic [TAG_W-1:0]       tag;
   logic [WAYS-1:0]        match, free;
   logic [WW-1:0]          hit_way, fill_way, victim, way_sel;
   logic [VALUE_WIDTH-1:0] hit_val;
   logic                   busy, hit_c, wr_fire, advance;
   logic                   hit_q;
   logic [VALUE_WIDTH-1:0] out_q;

   assign tag = bus.key[KEY_WIDTH-1 -: TAG_W];
   generate
      if (SETS > 1) begin : g_idx
         assign idx = bus.key[$clog2(SETS)-1:0];
      end else begin : g_noidx
         assign idx = '0;
      end
   endgenerate

   // FSM: a flush pulse walks fcnt over every set, one per cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         IDLE: if (bus.flush) begin
            state_d = FLUSH;
            fcnt_d  = '0;
         end
         FLUSH: begin
            if (fcnt_q == IW'(SETS - 1)) state_d = IDLE;
            else                         fcnt_d  = fcnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy     = (state_q == FLUSH);
   assign bus.busy = busy;

   // Tags are unique within a set, so the matching value can simply be OR-reduced.
   always_comb begin
      match    = '0;
      free     = '0;
      hit_way  = '0;
      fill_way = '0;
      hit_val  = '0;
      for (int w = 0; w < WAYS; w++) begin
         match[w] = mem[idx][w].valid && (mem[idx][w].tag == tag);
         free[w]  = !mem[idx][w].valid;
         hit_val  = hit_val | ({VALUE_WIDTH{match[w]}} & mem[idx][w].value);
         if (match[w]) hit_way = WW'(w);
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (free[w]) fill_way = WW'(w);
      end
   end

   assign hit_c   = |match && !busy;
   assign wr_fire = bus.write && !bus.flush && !busy;
   assign advance = wr_fire && !(|match) && !(|free);
   assign way_sel = (|match) ? hit_way : (|free) ? fill_way : victim;

   cpu_tlb_rr_ptr #(.SETS(SETS), .WAYS(WAYS)) u_rr (
      .clock     (clock),
      .reset     (reset),
      .set       (busy ? fcnt_q : idx),
      .advance   (advance),
      .clear_set (busy),
      .victim    (victim)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) mem[s][w] <= '0;
      end else if (busy) begin
         for (int w = 0; w < WAYS; w++) mem[fcnt_q][w].valid <= 1'b0;
      end else if (wr_fire) begin
         mem[idx][way_sel] <= '{valid: 1'b1, tag: tag, value: bus.value};
      end
   end

   // Lookup result reflects pre-write contents since mem updates on the same edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hit_q <= 1'b0;
         out_q <= '0;
      end else if (bus.lookup) begin
         hit_q <= hit_c;
         out_q <= hit_c ? hit_val : '0;
      end
   end

   assign bus.hit = hit_q;
   assign bus.out = out_q;

`ifdef CPU_TLB_STATS_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (bus.lookup) begin
         if (hit_c) begin
            if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
         end else begin
            if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cpu_tlb_setassoc.sv
// Scoreboard bench for cpu_tlb_setassoc: directed scenarios followed by random traffic against a behavioural model.
module tb_cpu_tlb_setassoc;
   localparam int SETS = 2, WAYS = 2, KW = 16, VW = 16;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   cpu_tlb_setassoc_if #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW)) bus ();
`ifdef CPU_TLB_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   cpu_tlb_setassoc #(.SETS(SETS), .WAYS(WAYS), .KEY_WIDTH(KW), .VALUE_WIDTH(VW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
`ifdef CPU_TLB_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   typedef struct {
      int            step;
      logic          busy;
      logic          hit;
      logic [VW-1:0] out;
   } exp_t;

   exp_t expq[$];
   int   tests = 0;
   int   fails = 0;
   int   step  = 0;

   // Reference model: each set is a small table of full keys; a flush clears everything at once
   // and simply keeps the block busy for SETS cycles.
   logic          m_v [SETS][WAYS];
   logic [KW-1:0] m_k [SETS][WAYS];
   logic [VW-1:0] m_d [SETS][WAYS];
   int            m_ptr [SETS];
   int            m_bcnt = 0;
   logic          m_hit  = 1'b0;
   logic [VW-1:0] m_out  = '0;
   longint        m_hc = 0, m_mc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_model();
      for (int s = 0; s < SETS; s++) begin
         m_ptr[s] = 0;
         for (int w = 0; w < WAYS; w++) m_v[s][w] = 1'b0;
      end
   endtask

   task automatic model(input logic r, input logic [KW-1:0] k, input logic lk, input logic wr,
                        input logic [VW-1:0] v, input logic fl);
      int s, found, fre;
      if (!r) begin
         clear_model();
         m_hit = 1'b0; m_out = '0; m_bcnt = 0; m_hc = 0; m_mc = 0;
         return;
      end
      s = int'(k) % SETS;
      if (lk) begin
         m_hit = 1'b0; m_out = '0;
         if (m_bcnt == 0)
            for (int w = 0; w < WAYS; w++)
               if (m_v[s][w] && m_k[s][w] == k) begin m_hit = 1'b1; m_out = m_d[s][w]; end
         if (m_hit) m_hc++; else m_mc++;
      end
      if (m_bcnt > 0) m_bcnt--;
      else if (fl) begin
         m_bcnt = SETS;
         clear_model();
      end else if (wr) begin
         found = -1; fre = -1;
         for (int w = 0; w < WAYS; w++) if (m_v[s][w] && m_k[s][w] == k) found = w;
         for (int w = WAYS - 1; w >= 0; w--) if (!m_v[s][w]) fre = w;
         if (found >= 0) m_d[s][found] = v;
         else begin
            if (fre < 0) begin
               fre = m_ptr[s];
               m_ptr[s] = (m_ptr[s] + 1) % WAYS;
            end
            m_v[s][fre] = 1'b1; m_k[s][fre] = k; m_d[s][fre] = v;
         end
      end
   endtask

   task automatic cyc(input logic r, input logic [KW-1:0] k, input logic lk, input logic wr,
                      input logic [VW-1:0] v, input logic fl);
      exp_t e;
      @(negedge clock);
      reset = r; bus.key = k; bus.lookup = lk; bus.write = wr; bus.value = v; bus.flush = fl;
      model(r, k, lk, wr, v, fl);
      step++;
      e.step = step; e.busy = (m_bcnt > 0); e.hit = m_hit; e.out = m_out;
      expq.push_back(e);
      if (!r) begin
         #1;
         chk($sformatf("async_rst_busy@%0d", step), 32'(bus.busy), 32'd0);
         chk($sformatf("async_rst_hit@%0d", step), 32'(bus.hit), 32'd0);
      end
   endtask

   task automatic lk(input logic [KW-1:0] k);                 cyc(1'b1, k, 1'b1, 1'b0, '0, 1'b0); endtask
   task automatic wr(input logic [KW-1:0] k, input logic [VW-1:0] v); cyc(1'b1, k, 1'b0, 1'b1, v, 1'b0); endtask
   task automatic idle();                                     cyc(1'b1, '0, 1'b0, 1'b0, '0, 1'b0); endtask

   // Monitor: the DUT presents a fresh busy/hit/out every edge; compare each against the queue.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk($sformatf("busy@%0d", e.step), 32'(bus.busy), 32'(e.busy));
            chk($sformatf("hit@%0d", e.step), 32'(bus.hit), 32'(e.hit));
            chk($sformatf("out@%0d", e.step), 32'(bus.out), 32'(e.out));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.key = '0; bus.lookup = 1'b0; bus.write = 1'b0; bus.value = '0; bus.flush = 1'b0;
      cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      // 1: reset state
      lk(16'h10);
      // 2: fill set 0
      wr(16'h10, 16'h20); wr(16'h12, 16'h22);
      lk(16'h12); lk(16'h10); lk(16'h11);
      // 3: eviction of way 0
      wr(16'h14, 16'h24);
      lk(16'h10); lk(16'h14); lk(16'h12);
      // 4: in-place update, then eviction with pointer wrap
      wr(16'h12, 16'h2A); lk(16'h12);
      wr(16'h16, 16'h26);
      lk(16'h14); lk(16'h16); lk(16'h12);
      wr(16'h1C, 16'h2C); lk(16'h14); lk(16'h1C);
      // read-before-write on the same key
      cyc(1'b1, 16'h16, 1'b1, 1'b1, 16'h77, 1'b0); lk(16'h16);
      // 5: flush, write ignored while busy, flush+write drop
      cyc(1'b1, '0, 1'b0, 1'b0, '0, 1'b1);
      wr(16'h18, 16'h28);
      cyc(1'b1, 16'h1C, 1'b1, 1'b0, '0, 1'b1);
      lk(16'h14); lk(16'h16); lk(16'h18);
      cyc(1'b1, 16'h1A, 1'b0, 1'b1, 16'h55, 1'b1);
      idle(); idle();
      lk(16'h1A);
      // 6: reset aborts a flush
      wr(16'h1A, 16'h3A); lk(16'h1A);
      cyc(1'b1, '0, 1'b0, 1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      lk(16'h1A); lk(16'h1A); lk(16'h10);
      wr(16'h10, 16'h30); lk(16'h10);
      // random traffic on a small key space to force conflicts and evictions
      for (int i = 0; i < 600; i++) begin
         logic r, l, w, f;
         r = ($urandom_range(0, 199) != 0);
         l = ($urandom_range(0, 9) < 6);
         w = ($urandom_range(0, 1) == 1);
         f = ($urandom_range(0, 39) == 0);
         cyc(r, 16'($urandom_range(0, 11)), l, w, 16'($urandom), f);
      end
      idle(); idle();
      @(posedge clock);
      #2;
      chk("queue_drained", 32'(expq.size()), 32'd0);
`ifdef CPU_TLB_STATS_EN
      chk("hit_count", hit_count, 32'(m_hc));
      chk("miss_count", miss_count, 32'(m_mc));
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
